// File: rtl/instruction_prefetch.sv
// Clocked instruction fetch: owns the fetch PC and issues one read at a time over req/ack.
// Returned words are queued with their addresses, and a redirect restarts fetch at a new PC.
module instruction_prefetch #(
  parameter int          ADDR_W   = 8,
  parameter int          INSTR_W  = 16,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_ack,
  input  logic [INSTR_W-1:0]         mem_rdata,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       halt,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  output logic [INSTR_W-1:0]         ir,
  output logic [ADDR_W-1:0]          ir_pc,
  output logic [ADDR_W-1:0]          next_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } q_entry_t;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pend_pc;
  q_entry_t          q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;

  logic             pop;
  logic             push;
  logic [CNT_W-1:0] cnt_after;
  logic             room_now;
  logic             room_after;

  always_comb begin
    pop        = (count_q != '0) && ir_ready;
    push       = (state == REQ) && mem_ack && !redirect;
    cnt_after  = count_q + CNT_W'(push) - CNT_W'(pop);
    room_now   = count_q < CNT_W'(DEPTH);
    room_after = cnt_after < CNT_W'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      fetch_pc <= ADDR_W'(RESET_PC);
      pend_pc  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      // Redirect wins over any push or pop in the same cycle.
      if (redirect) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          q[wr_ptr] <= '{pc: fetch_pc, instr: mem_rdata};
          wr_ptr    <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count_q <= cnt_after;
      end

      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end else if (!halt && room_now) begin
            state   <= REQ;
            mem_req <= 1'b1;
          end
        end
        REQ: begin
          if (redirect && mem_ack) begin
            fetch_pc <= redirect_pc;
            state    <= IDLE;
            mem_req  <= 1'b0;
          end else if (redirect) begin
            // Request still in flight: its data must be swallowed before refetching.
            pend_pc <= redirect_pc;
            state   <= DISCARD;
          end else if (mem_ack) begin
            fetch_pc <= fetch_pc + ADDR_W'(1);
            if (halt || !room_after) begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (redirect && mem_ack) begin
            fetch_pc <= redirect_pc;
            state    <= IDLE;
            mem_req  <= 1'b0;
          end else if (redirect) begin
            pend_pc <= redirect_pc;
          end else if (mem_ack) begin
            fetch_pc <= pend_pc;
            state    <= IDLE;
            mem_req  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr = fetch_pc;
    ir_valid = count_q != '0;
    ir       = q[rd_ptr].instr;
    ir_pc    = q[rd_ptr].pc;
    next_pc  = q[rd_ptr].pc + ADDR_W'(1);
    count    = count_q;
  end

endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: directed vector table, reset-mid-request sequence,
// then randomized traffic checked against a queue-based reference model.
module tb_instruction_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halt;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic [7:0]  next_pc;
  logic [2:0]  count;

  instruction_prefetch #(.ADDR_W(8), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc),
    .next_pc(next_pc), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [15:0] word_at(input logic [7:0] a);
    return {8'hA0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic       ack, rdy, hlt, rdr;
    logic [7:0] rpc;
    logic       e_req;
    logic [7:0] e_addr;
    logic       e_vld;
    logic [7:0] e_pc;
    logic [2:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic ack, input logic rdy, input logic hlt, input logic rdr,
                              input logic [7:0] rpc, input logic req, input logic [7:0] addr,
                              input logic vld, input logic [7:0] pc, input logic [2:0] cnt);
    vec_t v;
    v.ack = ack; v.rdy = rdy; v.hlt = hlt; v.rdr = rdr; v.rpc = rpc;
    v.e_req = req; v.e_addr = addr; v.e_vld = vld; v.e_pc = pc; v.e_cnt = cnt;
    return v;
  endfunction

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] w;
  } ent_t;

  ent_t       mq[$];
  logic [7:0] m_fetch;
  logic [7:0] m_pend;
  bit         m_busy;
  bit         m_drop;

  task automatic reset_outputs_check(input string tag);
    chk({tag, ".mem_req"},  32'(mem_req),  32'(0));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(0));
    chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(0));
    chk({tag, ".count"},    32'(count),    32'(0));
    chk({tag, ".ir"},       32'(ir),       32'(0));
    chk({tag, ".ir_pc"},    32'(ir_pc),    32'(0));
    chk({tag, ".next_pc"},  32'(next_pc),  32'(1));
  endtask

  initial begin
    vec_t tbl[$];
    logic [7:0] np;
    int wcnt;
    logic rdy, hlt, rdr, ack;
    logic [7:0] rpc;

    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; redirect = 1'b0; redirect_pc = '0;
    halt = 1'b0; ir_ready = 1'b0;

    //               ack   rdy   hlt   rdr   rpc     req   addr    vld   pc     cnt
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0)); // c0
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h00, 3'd1));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h01, 3'd1));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h02, 3'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h03, 3'd1)); // c5
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 8'h03, 3'd2));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 8'h03, 3'd3));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h07, 1'b1, 8'h03, 3'd4)); // full
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h07, 1'b1, 8'h03, 3'd4));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h07, 1'b1, 8'h04, 3'd3)); // c10
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h07, 1'b1, 8'h04, 3'd3));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h07, 1'b1, 8'h04, 3'd3));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h07, 1'b1, 8'h04, 3'd3));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h08, 1'b1, 8'h04, 3'd4));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 8'h08, 1'b1, 8'h04, 3'd4)); // c15
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h40, 1'b0, 8'h00, 3'd0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 8'h00, 3'd0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 8'h40, 1'b0, 8'h00, 3'd0)); // discard
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 8'h00, 3'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 8'h00, 3'd0)); // c20
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h80, 1'b0, 8'h00, 3'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 8'h00, 3'd0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h81, 1'b1, 8'h80, 3'd1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h81, 1'b1, 8'h80, 3'd1));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'hFE, 1'b1, 8'h82, 1'b1, 8'h80, 3'd2)); // c25
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFE, 1'b0, 8'h00, 3'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFE, 1'b0, 8'h00, 3'd0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 8'hFE, 3'd1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'hFE, 3'd2));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'hFF, 3'd1)); // c30
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'hFF, 3'd1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'hFF, 3'd2));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'hFF, 3'd2));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h00, 3'd1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h00, 3'd1)); // c35

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_outputs_check("reset");

    foreach (tbl[i]) begin
      chk($sformatf("vec%0d.mem_req", i),  32'(mem_req),  32'(tbl[i].e_req));
      chk($sformatf("vec%0d.mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("vec%0d.ir_valid", i), 32'(ir_valid), 32'(tbl[i].e_vld));
      chk($sformatf("vec%0d.count", i),    32'(count),    32'(tbl[i].e_cnt));
      if (tbl[i].e_vld) begin
        np = tbl[i].e_pc + 8'd1;
        chk($sformatf("vec%0d.ir_pc", i),   32'(ir_pc),   32'(tbl[i].e_pc));
        chk($sformatf("vec%0d.ir", i),      32'(ir),      32'(word_at(tbl[i].e_pc)));
        chk($sformatf("vec%0d.next_pc", i), 32'(next_pc), 32'(np));
      end
      mem_ack     = tbl[i].ack;
      mem_rdata   = tbl[i].ack ? word_at(tbl[i].e_addr) : 16'hDEAD;
      ir_ready    = tbl[i].rdy;
      halt        = tbl[i].hlt;
      redirect    = tbl[i].rdr;
      redirect_pc = tbl[i].rpc;
      @(posedge clk);
      @(negedge clk);
    end

    // Reset while a request is outstanding abandons it.
    chk("midreq.pre_mem_req", 32'(mem_req), 32'(1));
    mem_ack = 1'b0; ir_ready = 1'b0; halt = 1'b0; redirect = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_outputs_check("midreq_rst");
    rst = 1'b0;

    // Randomized traffic against the reference model.
    mq.delete();
    m_fetch = 8'h00; m_pend = 8'h00; m_busy = 1'b0; m_drop = 1'b0;
    wcnt = -1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int   s0;
      bit   popm;
      chk("rand.mem_req",  32'(mem_req),  32'(m_busy));
      chk("rand.mem_addr", 32'(mem_addr), 32'(m_fetch));
      chk("rand.ir_valid", 32'(ir_valid), 32'(mq.size() > 0));
      chk("rand.count",    32'(count),    32'(mq.size()));
      if (mq.size() > 0) begin
        np = mq[0].pc + 8'd1;
        chk("rand.ir_pc",   32'(ir_pc),   32'(mq[0].pc));
        chk("rand.ir",      32'(ir),      32'(mq[0].w));
        chk("rand.next_pc", 32'(next_pc), 32'(np));
      end

      rdy = ($urandom % 3) != 0;
      hlt = ($urandom % 8) == 0;
      rdr = ($urandom % 24) == 0;
      rpc = (($urandom % 4) == 0) ? 8'($urandom_range(8'hFC, 8'hFF)) : 8'($urandom);
      ack = 1'b0;
      if (mem_req) begin
        if (wcnt < 0) wcnt = $urandom_range(0, 3);
        if (wcnt == 0) begin
          ack  = 1'b1;
          wcnt = -1;
        end else begin
          wcnt--;
        end
      end
      mem_ack     = ack;
      mem_rdata   = ack ? word_at(mem_addr) : 16'($urandom);
      ir_ready    = rdy;
      halt        = hlt;
      redirect    = rdr;
      redirect_pc = rpc;

      s0   = mq.size();
      popm = (s0 > 0) && rdy;
      if (rdr) begin
        mq.delete();
        if (m_busy && !ack) begin
          m_drop = 1'b1;
          m_pend = rpc;
        end else begin
          m_fetch = rpc;
          m_busy  = 1'b0;
          m_drop  = 1'b0;
        end
      end else begin
        if (popm) void'(mq.pop_front());
        if (m_busy && ack) begin
          if (m_drop) begin
            m_fetch = m_pend;
            m_busy  = 1'b0;
            m_drop  = 1'b0;
          end else begin
            mq.push_back('{pc: m_fetch, w: word_at(m_fetch)});
            m_fetch = m_fetch + 8'd1;
            m_busy  = !hlt && (mq.size() < DEPTH);
          end
        end else if (!m_busy) begin
          m_busy = !hlt && (s0 < DEPTH);
        end
      end

      @(posedge clk);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_prefetch.md
# instruction_prefetch

Parametrised, clocked successor to the combinational fetch stage. It owns the fetch program counter and issues one-at-a-time read requests to instruction memory over a req/ack handshake. Returned words are buffered with their addresses in a DEPTH-entry prefetch queue, and the queue head is presented to the decode/control stage as instruction, address and incremented PC. A redirect (branch/jump) flushes the queue and restarts fetch at a new address, discarding any in-flight return.

## Interface
Parameters:
- ADDR_W, 8, program-counter / memory-address width
- INSTR_W, 16, instruction word width
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_PC, 0, fetch address after reset

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- mem_req  out  1  read request to instruction memory
- mem_addr  out  ADDR_W  request address; stable while mem_req=1
- mem_ack  in  1  memory has returned mem_rdata this cycle
- mem_rdata  in  INSTR_W  returned instruction word, valid when mem_ack=1
- redirect  in  1  flush the queue and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- halt  in  1  suppress new requests; an outstanding request still completes
- ir_valid  out  1  queue non-empty; ir/ir_pc/next_pc are valid
- ir_ready  in  1  consumer accepts the head entry
- ir  out  INSTR_W  head instruction
- ir_pc  out  ADDR_W  address of the head instruction
- next_pc  out  ADDR_W  ir_pc+1 mod 2^ADDR_W
- count  out  $clog2(DEPTH+1)  current queue occupancy

## Operation
- State machine: IDLE, REQ, DISCARD. mem_req=1 exactly in REQ and DISCARD. mem_addr=fetch_pc.
- At most one outstanding request. Once mem_req rises, mem_req and mem_addr are held until mem_ack.
- IDLE:
  - redirect: fetch_pc←redirect_pc, queue flushed, stay IDLE.
  - else if !halt and count<DEPTH: →REQ.
- REQ, mem_ack=1, no redirect:
  - push {fetch_pc, mem_rdata}; fetch_pc←fetch_pc+1 (wraps 2^ADDR_W−1→0).
  - Stay REQ if !halt and post-update occupancy <DEPTH (back-to-back issue). Otherwise →IDLE.
- REQ, redirect=1, mem_ack=1: data dropped, queue flushed, fetch_pc←redirect_pc, →IDLE.
- REQ, redirect=1, mem_ack=0: queue flushed, redirect_pc saved in pend_pc, →DISCARD. mem_addr stays the old address.
- DISCARD:
  - mem_ack: data dropped, fetch_pc←pend_pc, →IDLE.
  - A further redirect overwrites pend_pc and flushes again.
- Queue behaviour:
  - Pop on ir_valid&&ir_ready.
  - Push and pop in the same cycle: count unchanged.
  - redirect overrides both push and pop (count←0).
  - Push never finds the queue full, because issue requires count<DEPTH and only one request is outstanding.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
- halt does not flush the queue or change fetch_pc; the consumer may keep draining.
- Reset: state IDLE, fetch_pc=RESET_PC, pend_pc=0, queue empty, all storage cleared. Outputs: mem_req=0, mem_addr=RESET_PC, ir_valid=0, ir=0, ir_pc=0, next_pc=1, count=0.
- When ir_valid=0, ir/ir_pc/next_pc are stable but not checked.

## Timing
- Issue latency: an IDLE→REQ decision in cycle t gives mem_req=1 in cycle t+1.
- Return latency: an ack in cycle t makes the entry visible (ir_valid=1, count incremented) in cycle t+1.
- Zero-wait memory (ack the same cycle as req) with ir_ready=1 sustains one instruction per cycle after a 2-cycle startup.
- Redirect in cycle t: ir_valid=0 in t+1. If IDLE or acked, the first request to redirect_pc is in t+2 at the earliest.
- Reset asserted mid-request abandons the transaction: mem_req=0 the next cycle. Memory must tolerate the dropped request.
- Pop of the last entry together with a push: ir_valid stays 1, and ir shows the new entry next cycle.

## Test plan
- Reset, RESET_PC=0, zero-wait memory returning word=0xA000+addr, ir_ready=1 → ir_pc 0,1,2,… on consecutive cycles from cycle 3; ir=0xA000+ir_pc; next_pc=ir_pc+1.
- ir_ready=0, DEPTH=4 → exactly 4 requests (addr 0..3), count=4, mem_req=0. Then ir_ready=1 for one cycle → count=3 and a request for addr 4 issues.
- mem_ack delayed 3 cycles, redirect to 0x40 in the second waiting cycle → mem_addr held at old address until ack, returned data not enqueued, next request addr=0x40, first ir_pc=0x40.
- Redirect coincident with mem_ack and with a pop on a 2-entry queue → count=0 next cycle, fetch resumes at redirect_pc, no stale entry ever visible.
- fetch_pc at 0xFE with ADDR_W=8 → requests 0xFE, 0xFF, 0x00; ir_pc=0xFF gives next_pc=0x00.
- halt raised while REQ outstanding → that word is enqueued, no further mem_req until halt drops. rst asserted mid-REQ → mem_req=0 and count=0 next cycle.
